// File: rtl/branch_ctrl_if.sv
// Branch request/response bundle between decode, the branch controller and fetch.
// master: decode + fetch side; slave: the branch controller.
interface branch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_kind;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;

  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_misalign;
  logic            res_illegal;
  logic            flush;

  modport master (
    output req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2, res_ready,
    input  req_ready, res_valid, res_taken, res_target, res_link, res_misalign, res_illegal, flush
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_pc, req_imm, req_rs1, req_rs2, res_ready,
    output req_ready, res_valid, res_taken, res_target, res_link, res_misalign, res_illegal, flush
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: accepts one conditional branch / JAL / JALR op, drives the
// external comparator for one cycle, resolves taken/target/link and holds the
// result until fetch consumes it, pulsing flush on a good taken redirect.
// Optional statistics counters are built when BRANCH_CTRL_STATS_EN is defined.
module branch_ctrl #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  branch_ctrl_if.slave    bus,
  output logic [XLEN-1:0] cmp_rs1,
  output logic [XLEN-1:0] cmp_rs2,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic            br_ltu
`ifdef BRANCH_CTRL_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_total,
  output logic [31:0]     stat_taken
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;

  logic [1:0]      kind_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  logic            res_valid_q;
  logic            res_taken_q;
  logic [XLEN-1:0] res_target_q;
  logic [XLEN-1:0] res_link_q;
  logic            res_misalign_q;
  logic            res_illegal_q;

  logic            req_ready_int;
  logic            accept;

  logic            dec_taken;
  logic            dec_illegal;
  logic [XLEN-1:0] jump_sum;
  logic [XLEN-1:0] dec_target;
  logic            dec_misalign;

  // A new op can enter when idle, or in the same cycle the held result is consumed.
  assign req_ready_int = rst_n & ~kill &
                         ((state == IDLE) | ((state == RESP) & bus.res_ready));
  assign accept        = bus.req_valid & req_ready_int;
  assign bus.req_ready = req_ready_int;

  assign cmp_rs1 = rs1_q;
  assign cmp_rs2 = rs2_q;

  assign bus.res_valid    = res_valid_q;
  assign bus.res_taken    = res_taken_q;
  assign bus.res_target   = res_target_q;
  assign bus.res_link     = res_link_q;
  assign bus.res_misalign = res_misalign_q;
  assign bus.res_illegal  = res_illegal_q;
  assign bus.flush        = res_valid_q & bus.res_ready & res_taken_q & ~res_misalign_q & ~kill;

  // Resolve the captured op against the comparator flags seen during the CMP cycle.
  always_comb begin
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    case (kind_q)
      2'b00: begin
        case (funct3_q)
          3'b000:  dec_taken = br_eq;
          3'b001:  dec_taken = ~br_eq;
          3'b100:  dec_taken = br_lt;
          3'b101:  dec_taken = ~br_lt;
          3'b110:  dec_taken = br_ltu;
          3'b111:  dec_taken = ~br_ltu;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b01, 2'b10: dec_taken = 1'b1;
      default:      dec_illegal = 1'b1;
    endcase

    if (kind_q == 2'b10) begin
      jump_sum = (rs1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0};
    end else begin
      jump_sum = pc_q + imm_q;
    end

    dec_target   = dec_taken ? jump_sum : (pc_q + XLEN'(4));
    dec_misalign = dec_taken & (IALIGN == 32) & dec_target[1];
  end

  // Capture the request fields on every accepted handshake; they feed the comparator until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q   <= 2'b00;
      funct3_q <= 3'b000;
      pc_q     <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (accept) begin
      kind_q   <= bus.req_kind;
      funct3_q <= bus.req_funct3;
      pc_q     <= bus.req_pc;
      imm_q    <= bus.req_imm;
      rs1_q    <= bus.req_rs1;
      rs2_q    <= bus.req_rs2;
    end
  end

  // Sequencing FSM with registered result outputs; kill aborts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      res_valid_q    <= 1'b0;
      res_taken_q    <= 1'b0;
      res_target_q   <= '0;
      res_link_q     <= '0;
      res_misalign_q <= 1'b0;
      res_illegal_q  <= 1'b0;
    end else if (kill) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CMP;
          end
        end
        CMP: begin
          state          <= RESP;
          res_valid_q    <= 1'b1;
          res_taken_q    <= dec_taken;
          res_target_q   <= dec_target;
          res_link_q     <= pc_q + XLEN'(4);
          res_misalign_q <= dec_misalign;
          res_illegal_q  <= dec_illegal;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= accept ? CMP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic handshake;

  assign handshake = res_valid_q & bus.res_ready & ~kill;

  // Saturating result counters; a clear beats an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (stat_clr) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (handshake) begin
      if (stat_total != 32'hFFFF_FFFF) begin
        stat_total <= stat_total + 32'd1;
      end
      if (res_taken_q && (stat_taken != 32'hFFFF_FFFF)) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl. Two instances (IALIGN 32 and 16) share
// the same stimulus; each gets its own behavioural comparator.
module tb_branch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        kill;
  logic        req_valid;
  logic        res_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc, req_imm, req_rs1, req_rs2;

  int checks = 0;
  int fails  = 0;

  branch_ctrl_if #(.XLEN(32)) bus_a ();
  branch_ctrl_if #(.XLEN(32)) bus_b ();

  assign bus_a.req_valid  = req_valid;
  assign bus_a.req_kind   = req_kind;
  assign bus_a.req_funct3 = req_funct3;
  assign bus_a.req_pc     = req_pc;
  assign bus_a.req_imm    = req_imm;
  assign bus_a.req_rs1    = req_rs1;
  assign bus_a.req_rs2    = req_rs2;
  assign bus_a.res_ready  = res_ready;
  assign bus_b.req_valid  = req_valid;
  assign bus_b.req_kind   = req_kind;
  assign bus_b.req_funct3 = req_funct3;
  assign bus_b.req_pc     = req_pc;
  assign bus_b.req_imm    = req_imm;
  assign bus_b.req_rs1    = req_rs1;
  assign bus_b.req_rs2    = req_rs2;
  assign bus_b.res_ready  = res_ready;

  logic [31:0] cmp_rs1_a, cmp_rs2_a, cmp_rs1_b, cmp_rs2_b;
  logic eq_a, lt_a, ltu_a, eq_b, lt_b, ltu_b;

  assign eq_a  = (cmp_rs1_a == cmp_rs2_a);
  assign lt_a  = ($signed(cmp_rs1_a) < $signed(cmp_rs2_a));
  assign ltu_a = (cmp_rs1_a < cmp_rs2_a);
  assign eq_b  = (cmp_rs1_b == cmp_rs2_b);
  assign lt_b  = ($signed(cmp_rs1_b) < $signed(cmp_rs2_b));
  assign ltu_b = (cmp_rs1_b < cmp_rs2_b);

`ifdef BRANCH_CTRL_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_total_a, stat_taken_a, stat_total_b, stat_taken_b;
  int unsigned exp_total, exp_taken;
`endif

  branch_ctrl #(.XLEN(32), .IALIGN(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .kill(kill), .bus(bus_a),
    .cmp_rs1(cmp_rs1_a), .cmp_rs2(cmp_rs2_a),
    .br_eq(eq_a), .br_lt(lt_a), .br_ltu(ltu_a)
`ifdef BRANCH_CTRL_STATS_EN
    , .stat_clr(stat_clr), .stat_total(stat_total_a), .stat_taken(stat_taken_a)
`endif
  );

  branch_ctrl #(.XLEN(32), .IALIGN(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .kill(kill), .bus(bus_b),
    .cmp_rs1(cmp_rs1_b), .cmp_rs2(cmp_rs2_b),
    .br_eq(eq_b), .br_lt(lt_b), .br_ltu(ltu_b)
`ifdef BRANCH_CTRL_STATS_EN
    , .stat_clr(stat_clr), .stat_total(stat_total_b), .stat_taken(stat_taken_b)
`endif
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        misalign;
    logic        illegal;
  } res_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        ill;
    logic        mis32;
    logic        mis16;
  } vec_t;

  // Architectural meaning of a branch op, straight from the ISA rules.
  function automatic res_t model(input logic [1:0] kind, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input bit align16);
    res_t        r;
    logic [31:0] dest;
    bit          t, ill, c;
    t = 1'b0; ill = 1'b0; c = 1'b0;
    if (kind == 2'd0) begin
      if (f3 == 3'd2 || f3 == 3'd3) begin
        ill = 1'b1;
      end else begin
        case (f3[2:1])
          2'd0:    c = (rs1 == rs2);
          2'd2:    c = ($signed(rs1) < $signed(rs2));
          2'd3:    c = (rs1 < rs2);
          default: c = 1'b0;
        endcase
        t = f3[0] ? !c : c;
      end
    end else if (kind == 2'd3) begin
      ill = 1'b1;
    end else begin
      t = 1'b1;
    end
    dest       = (kind == 2'd2) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    r.taken    = t;
    r.target   = t ? dest : pc + 32'd4;
    r.link     = pc + 32'd4;
    r.misalign = t && !align16 && r.target[1];
    r.illegal  = ill;
    return r;
  endfunction

`ifdef BRANCH_CTRL_STATS_EN
  // Count every completed result handshake as seen at the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_total <= 0;
      exp_taken <= 0;
    end else if (stat_clr) begin
      exp_total <= 0;
      exp_taken <= 0;
    end else if (bus_a.res_valid && res_ready && !kill) begin
      exp_total <= exp_total + 1;
      if (bus_a.res_taken) exp_taken <= exp_taken + 1;
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, waits for its result (bounded), holds it, then consumes it.
  task automatic send_op(input logic [1:0] kind, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input int hold, output int lat,
                         output res_t got_a, output res_t got_b,
                         output logic fl_a, output logic fl_b);
    req_valid = 1'b1; req_kind = kind; req_funct3 = f3;
    req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!bus_a.res_valid && lat < 8) begin
      tick();
      lat++;
    end
    repeat (hold) tick();
    got_a = '{bus_a.res_taken, bus_a.res_target, bus_a.res_link, bus_a.res_misalign, bus_a.res_illegal};
    got_b = '{bus_b.res_taken, bus_b.res_target, bus_b.res_link, bus_b.res_misalign, bus_b.res_illegal};
    res_ready = 1'b1;
    #1;
    fl_a = bus_a.flush;
    fl_b = bus_b.flush;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus_a.req_ready !== 1'b0 || bus_b.req_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_req_ready: got %b/%b expected 0", bus_a.req_ready, bus_b.req_ready);
    end
    checks++;
    if ({bus_a.res_valid, bus_a.res_taken, bus_a.res_target, bus_a.res_link, bus_a.flush} !== '0) begin
      fails++; $display("[TB] FAIL reset_res: got valid=%b target=%h link=%h expected all 0",
                        bus_a.res_valid, bus_a.res_target, bus_a.res_link);
    end
    checks++;
    if (cmp_rs1_a !== 32'h0 || cmp_rs2_a !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_cmp: got %h/%h expected 0/0", cmp_rs1_a, cmp_rs2_a);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (bus_a.req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL idle_req_ready: got %b expected 1", bus_a.req_ready);
    end
  endtask

  task automatic test_directed();
    vec_t v[10];
    res_t ga, gb;
    logic fa, fb;
    int   lat;
    v[0] = '{2'd0, 3'd0, 32'h100, 32'h20, 32'h5, 32'h5, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0, 1'b0};
    v[1] = '{2'd0, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h240, 32'h204, 1'b0, 1'b0, 1'b0};
    v[2] = '{2'd0, 3'd6, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h104, 32'h104, 1'b0, 1'b0, 1'b0};
    v[3] = '{2'd2, 3'd0, 32'h300, 32'h2, 32'h1001, 32'h0, 1'b1, 32'h1002, 32'h304, 1'b0, 1'b1, 1'b0};
    v[4] = '{2'd0, 3'd2, 32'h400, 32'h10, 32'h3, 32'h3, 1'b0, 32'h404, 32'h404, 1'b1, 1'b0, 1'b0};
    v[5] = '{2'd0, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h7, 32'h7, 1'b1, 32'h10, 32'hFFFF_FFF4, 1'b0, 1'b0, 1'b0};
    v[6] = '{2'd1, 3'd5, 32'h500, 32'hFFFF_FF00, 32'h9, 32'h9, 1'b1, 32'h400, 32'h504, 1'b0, 1'b0, 1'b0};
    v[7] = '{2'd3, 3'd0, 32'h600, 32'h8, 32'h1, 32'h1, 1'b0, 32'h604, 32'h604, 1'b1, 1'b0, 1'b0};
    v[8] = '{2'd0, 3'd1, 32'h700, 32'h6, 32'h1, 32'h2, 1'b1, 32'h706, 32'h704, 1'b0, 1'b1, 1'b0};
    v[9] = '{2'd0, 3'd5, 32'h800, 32'h8, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h808, 32'h804, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_op(v[i].kind, v[i].f3, v[i].pc, v[i].imm, v[i].rs1, v[i].rs2,
              int'($urandom_range(0, 2)), lat, ga, gb, fa, fb);
      checks++;
      if (lat !== 1) begin
        fails++; $display("[TB] FAIL dir_latency[%0d]: got %0d expected 1", i, lat);
      end
      checks++;
      if (ga.taken !== v[i].taken || gb.taken !== v[i].taken) begin
        fails++; $display("[TB] FAIL dir_taken[%0d]: got %b/%b expected %b", i, ga.taken, gb.taken, v[i].taken);
      end
      checks++;
      if (ga.target !== v[i].target || gb.target !== v[i].target) begin
        fails++; $display("[TB] FAIL dir_target[%0d]: got %h/%h expected %h", i, ga.target, gb.target, v[i].target);
      end
      checks++;
      if (ga.link !== v[i].link) begin
        fails++; $display("[TB] FAIL dir_link[%0d]: got %h expected %h", i, ga.link, v[i].link);
      end
      checks++;
      if (ga.illegal !== v[i].ill || gb.illegal !== v[i].ill) begin
        fails++; $display("[TB] FAIL dir_illegal[%0d]: got %b/%b expected %b", i, ga.illegal, gb.illegal, v[i].ill);
      end
      checks++;
      if (ga.misalign !== v[i].mis32 || gb.misalign !== v[i].mis16) begin
        fails++; $display("[TB] FAIL dir_misalign[%0d]: got %b/%b expected %b/%b", i, ga.misalign, gb.misalign, v[i].mis32, v[i].mis16);
      end
      checks++;
      if (fa !== (v[i].taken & ~v[i].mis32) || fb !== (v[i].taken & ~v[i].mis16)) begin
        fails++; $display("[TB] FAIL dir_flush[%0d]: got %b/%b expected %b/%b", i, fa, fb,
                          v[i].taken & ~v[i].mis32, v[i].taken & ~v[i].mis16);
      end
      checks++;
      if (bus_a.flush !== 1'b0 || cmp_rs1_a !== v[i].rs1) begin
        fails++; $display("[TB] FAIL dir_after: got flush=%b cmp_rs1=%h expected 0/%h", bus_a.flush, cmp_rs1_a, v[i].rs1);
      end
    end
  endtask

  task automatic test_random();
    res_t ga, gb, ea, eb;
    logic fa, fb;
    int   lat;
    logic [1:0]  k;
    logic [2:0]  f;
    logic [31:0] pc, imm, a, b;
    for (int i = 0; i < 40; i++) begin
      k   = ($urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
      f   = 3'($urandom);
      pc  = $urandom;
      imm = ($urandom_range(0, 1) != 0) ? 32'($signed(12'($urandom))) : $urandom;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom : ~a);
      ea  = model(k, f, pc, imm, a, b, 1'b0);
      eb  = model(k, f, pc, imm, a, b, 1'b1);
      send_op(k, f, pc, imm, a, b, int'($urandom_range(0, 2)), lat, ga, gb, fa, fb);
      checks++;
      if (lat !== 1) begin
        fails++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 1", i, lat);
      end
      checks++;
      if (ga !== ea) begin
        fails++; $display("[TB] FAIL rand_res32[%0d]: got t=%b tgt=%h lnk=%h m=%b i=%b expected t=%b tgt=%h lnk=%h m=%b i=%b",
                          i, ga.taken, ga.target, ga.link, ga.misalign, ga.illegal,
                          ea.taken, ea.target, ea.link, ea.misalign, ea.illegal);
      end
      checks++;
      if (gb !== eb) begin
        fails++; $display("[TB] FAIL rand_res16[%0d]: got t=%b tgt=%h m=%b expected t=%b tgt=%h m=%b",
                          i, gb.taken, gb.target, gb.misalign, eb.taken, eb.target, eb.misalign);
      end
      checks++;
      if (fa !== (ea.taken & ~ea.misalign) || fb !== (eb.taken & ~eb.misalign)) begin
        fails++; $display("[TB] FAIL rand_flush[%0d]: got %b/%b expected %b/%b", i, fa, fb,
                          ea.taken & ~ea.misalign, eb.taken & ~eb.misalign);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t snap, now, e2;
    e2 = model(2'd1, 3'd0, 32'h9000, 32'h40, 32'hAAAA, 32'h5555, 1'b0);
    req_valid = 1'b1; req_kind = 2'd0; req_funct3 = 3'd0;
    req_pc = 32'h100; req_imm = 32'h20; req_rs1 = 32'h5; req_rs2 = 32'h5;
    tick();
    req_valid = 1'b0;
    tick();
    snap = '{bus_a.res_taken, bus_a.res_target, bus_a.res_link, bus_a.res_misalign, bus_a.res_illegal};
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_kind = 2'd1; req_pc = 32'h9000; req_imm = 32'h40;
      req_rs1 = 32'hAAAA; req_rs2 = 32'h5555;
      #1;
      now = '{bus_a.res_taken, bus_a.res_target, bus_a.res_link, bus_a.res_misalign, bus_a.res_illegal};
      checks++;
      if (bus_a.res_valid !== 1'b1 || now !== snap || now.target !== 32'h120) begin
        fails++; $display("[TB] FAIL hold_stable[%0d]: got valid=%b target=%h expected 1/00000120", c, bus_a.res_valid, now.target);
      end
      checks++;
      if (bus_a.req_ready !== 1'b0 || bus_a.flush !== 1'b0 || cmp_rs1_a !== 32'h5) begin
        fails++; $display("[TB] FAIL hold_ready: got ready=%b flush=%b cmp=%h expected 0/0/00000005",
                          bus_a.req_ready, bus_a.flush, cmp_rs1_a);
      end
      tick();
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b1 || bus_a.flush !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_accept: got ready=%b flush=%b expected 1/1", bus_a.req_ready, bus_a.flush);
    end
    tick();
    req_valid = 1'b0;
    #1;
    checks++;
    if (bus_a.res_valid !== 1'b0 || bus_a.flush !== 1'b0 || cmp_rs1_a !== 32'hAAAA) begin
      fails++; $display("[TB] FAIL b2b_cmp: got valid=%b flush=%b cmp=%h expected 0/0/0000aaaa",
                        bus_a.res_valid, bus_a.flush, cmp_rs1_a);
    end
    tick();
    now = '{bus_a.res_taken, bus_a.res_target, bus_a.res_link, bus_a.res_misalign, bus_a.res_illegal};
    checks++;
    if (bus_a.res_valid !== 1'b1 || now !== e2) begin
      fails++; $display("[TB] FAIL b2b_result: got valid=%b target=%h link=%h expected 1/%h/%h",
                        bus_a.res_valid, now.target, now.link, e2.target, e2.link);
    end
    tick();
    res_ready = 1'b0;
    checks++;
    if (bus_a.res_valid !== 1'b0 || bus_a.flush !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_done: got valid=%b flush=%b expected 0/0", bus_a.res_valid, bus_a.flush);
    end
  endtask

  task automatic test_kill();
    req_valid = 1'b1; req_kind = 2'd1; req_funct3 = 3'd0;
    req_pc = 32'h40; req_imm = 32'h100; req_rs1 = 32'h0; req_rs2 = 32'h0;
    tick();
    req_valid = 1'b0; kill = 1'b1; res_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL kill_cmp_ready: got %b expected 0", bus_a.req_ready);
    end
    tick();
    kill = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus_a.res_valid !== 1'b0 || bus_a.flush !== 1'b0) begin
        fails++; $display("[TB] FAIL kill_cmp_quiet[%0d]: got valid=%b flush=%b expected 0/0", c, bus_a.res_valid, bus_a.flush);
      end
      tick();
    end
    res_ready = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    res_ready = 1'b1; kill = 1'b1;
    #1;
    checks++;
    if (bus_a.res_valid !== 1'b1 || bus_a.flush !== 1'b0) begin
      fails++; $display("[TB] FAIL kill_resp_flush: got valid=%b flush=%b expected 1/0", bus_a.res_valid, bus_a.flush);
    end
    tick();
    kill = 1'b0; res_ready = 1'b0;
    checks++;
    if (bus_a.res_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL kill_resp_valid: got %b expected 0", bus_a.res_valid);
    end
    req_valid = 1'b1; kill = 1'b1;
    #1;
    checks++;
    if (bus_a.req_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL kill_idle_ready: got %b expected 0", bus_a.req_ready);
    end
    tick();
    req_valid = 1'b0; kill = 1'b0;
    tick();
    checks++;
    if (bus_a.res_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL kill_idle_drop: got valid=%b ready=%b expected 0/1", bus_a.res_valid, bus_a.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_kind = 2'd0; req_funct3 = 3'd0;
    req_pc = 32'h100; req_imm = 32'h20; req_rs1 = 32'h33; req_rs2 = 32'h33;
    tick();
    req_valid = 1'b0;
    tick();
    res_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.res_valid !== 1'b1 || bus_a.flush !== 1'b1) begin
      fails++; $display("[TB] FAIL rstmid_pre: got valid=%b flush=%b expected 1/1", bus_a.res_valid, bus_a.flush);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.res_valid !== 1'b0 || bus_a.flush !== 1'b0 || bus_a.req_ready !== 1'b0 ||
        bus_a.res_taken !== 1'b0 || bus_a.res_target !== 32'h0 || cmp_rs1_a !== 32'h0) begin
      fails++; $display("[TB] FAIL rstmid_async: got valid=%b flush=%b ready=%b target=%h cmp=%h expected all 0",
                        bus_a.res_valid, bus_a.flush, bus_a.req_ready, bus_a.res_target, cmp_rs1_a);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b0;
    tick();
    checks++;
    if (bus_a.res_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL rstmid_after: got valid=%b ready=%b expected 0/1", bus_a.res_valid, bus_a.req_ready);
    end
  endtask

`ifdef BRANCH_CTRL_STATS_EN
  task automatic test_stats();
    res_t ga, gb;
    logic fa, fb;
    int   lat;
    send_op(2'd0, 3'd1, 32'h10, 32'h8, 32'h1, 32'h1, 0, lat, ga, gb, fa, fb);
    send_op(2'd1, 3'd0, 32'h10, 32'h8, 32'h1, 32'h1, 0, lat, ga, gb, fa, fb);
    checks++;
    if (stat_total_a !== exp_total || stat_taken_a !== exp_taken) begin
      fails++; $display("[TB] FAIL stats_count: got %0d/%0d expected %0d/%0d", stat_total_a, stat_taken_a, exp_total, exp_taken);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (stat_total_a !== 32'h0 || stat_taken_a !== 32'h0) begin
      fails++; $display("[TB] FAIL stats_clear: got %0d/%0d expected 0/0", stat_total_a, stat_taken_a);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; kill = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_kind = 2'd0; req_funct3 = 3'd0;
    req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
`ifdef BRANCH_CTRL_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    test_reset_mid();
`ifdef BRANCH_CTRL_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
